output_sram_streamer: RTL
=========================

// Module: output_sram_streamer
// PURPOSE
//  Initiator for the output-SRAM request interface (w_en/r_en pulse, w_done/d_ready reply).
//  Executes one command at a time:
//   - STORE: writes LEN 128-bit words from the result stream into output SRAM.
//   - DRAIN: reads LEN words back out to a downstream stream.
//  Sits between the PE array writeback / DMA drain logic and the output SRAM controller.
// PARAMETERS
//  TIMEOUT  64     cycles to wait for w_done/d_ready before aborting with err
//  LEN_W    14     width of cmd_len (max 12288 words)
// PORTS
//  clock        in   1    single clock, all logic on posedge
//  reset        in   1    asynchronous, active-low reset
//  cmd_valid    in   1    command offered
//  cmd_ready    out  1    command accepted when cmd_valid&&cmd_ready
//  cmd_dir      in   1    0=STORE, 1=DRAIN
//  cmd_base     in   14   first linear word address ([13:11] bank 0..5, [10:0] row)
//  cmd_len      in   LEN_W  words to transfer; 0 allowed
//  in_valid     in   1    STORE data valid
//  in_ready     out  1    STORE data accepted
//  in_data      in   128  STORE data word
//  out_valid    out  1    DRAIN data valid
//  out_ready    in   1    DRAIN data consumed
//  out_data     out  128  DRAIN data word
//  done         out  1    1-cycle pulse: command finished (also pulsed on err)
//  err          out  1    1-cycle pulse: range reject or timeout
//  w_en, r_en   out  1    registered 1-cycle request pulses, never both high
//  w_addr       out  32   [13:0] address, [31:14]=0
//  r_addr       out  32   [13:0] address, [31:14]=0
//  w_d          out  128  write data, held from w_en until w_done
//  r_d          in   128  read data, sampled only when d_ready=1
//  w_done       in   1    write acknowledge
//  d_ready      in   1    read data valid
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0; state IDLE; counters/timer 0; in-flight access abandoned.
//  States: IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT, R_HOLD, FIN.
//  IDLE
//   - cmd_ready=1.
//   - On accept: if cmd_base+cmd_len > 12288 -> err=1 and done=1 next cycle, stay IDLE.
//   - Else if cmd_len==0 -> FIN.
//   - Else latch addr=cmd_base, remain=cmd_len; go W_REQ (STORE) or R_REQ (DRAIN).
//  W_REQ
//   - in_ready=1.
//   - On in_valid: register w_en=1, w_addr=addr, w_d=in_data; go W_WAIT.
//  W_WAIT
//   - w_en drops after exactly 1 cycle; timer counts.
//   - On w_done: addr++, remain--; go FIN if remain==0, else W_REQ.
//   - Nominal cost: 3 cycles/word.
//  R_REQ: register r_en=1, r_addr=addr; go R_WAIT.
//  R_WAIT
//   - On d_ready: capture r_d into out_data, out_valid=1; addr++, remain--; go R_HOLD.
//  R_HOLD
//   - Hold out_data/out_valid until out_ready.
//   - Then out_valid=0; go FIN if remain==0, else R_REQ.
//   - The next read is never issued while out_valid=1.
//  FIN: done=1 for one cycle; go IDLE.
//  Timeout: timer reaching TIMEOUT in W_WAIT/R_WAIT -> err=1 and done=1, go IDLE;
//   remaining words dropped.
//  Addressing: linear +1; row 2047 -> next bank row 0 (natural carry into [13:11]);
//   never exceeds 12287 because range is checked at accept.
//  Ignored inputs: w_done/d_ready outside W_WAIT/R_WAIT; in_valid outside W_REQ.
// STRUCTURE
//  output_sram_pkg:
//   - constants: NUM_BANKS=6, BANK_DEPTH=2048, ADDR_W=14, DATA_W=128, MAX_WORDS=12288.
//   - types: state_t enum, cmd_dir_t.
//  Sub-module output_sram_addr_gen: load/increment address and remain counters,
//   range check, last flag.
// TESTING
//  1. STORE base=0x07FE len=4, in_valid=1 -> w_addr 0x07FE,0x07FF,0x0800,0x0801;
//     each w_en 1 cycle; done 1 cycle after 4th w_done.
//  2. DRAIN base=0x2FFC len=4, out_ready low 5 cycles per word -> 4 words in order;
//     no r_en while out_valid=1; done after last handshake.
//  3. cmd_len=0 -> no w_en/r_en; done=1 two cycles after accept; err=0.
//  4. base=12286 len=3 -> err=1 and done=1; no SRAM request; cmd_ready back high.
//  5. Responder withholds w_done -> err=1 and done=1 exactly TIMEOUT cycles after w_en.
//  6. reset=0 mid-DRAIN with out_valid=1 -> all outputs 0 immediately;
//     after release, IDLE with cmd_ready=1.

Source files
------------

// File: rtl/output_sram_pkg.sv
// Shared constants and types for the output-SRAM streamer.
//   NUM_BANKS/BANK_DEPTH : SRAM geometry (6 banks x 2048 rows of 128-bit words)
//   ADDR_W/DATA_W        : linear word address width, SRAM word width
//   MAX_WORDS            : number of addressable words (base+len must not exceed it)
//   state_t              : streamer FSM states
//   cmd_dir_t            : command direction (STORE writes SRAM, DRAIN reads it)
package output_sram_pkg;

   localparam int unsigned NUM_BANKS  = 6;
   localparam int unsigned BANK_DEPTH = 2048;
   localparam int unsigned ADDR_W     = 14;
   localparam int unsigned DATA_W     = 128;
   localparam int unsigned MAX_WORDS  = NUM_BANKS * BANK_DEPTH;

   typedef enum logic [2:0] {
      StIdle,
      StWReq,
      StWWait,
      StRReq,
      StRWait,
      StRHold,
      StFin
   } state_t;

   typedef enum logic {
      DirStore = 1'b0,
      DirDrain = 1'b1
   } cmd_dir_t;

endpackage

// File: rtl/output_sram_addr_gen.sv
// Address / remaining-word counters for one streamer command.
//   clock, reset : clock and asynchronous active-low reset
//   load         : capture base/len as the new address and word count
//   step         : one word completed (address +1, remain -1)
//   base, len    : command start address and length (also used for the range check)
//   addr, remain : current word address and words still to transfer
//   last         : current word is the final one of the command
//   range_err    : base+len runs past the end of the SRAM (combinational on base/len)
module output_sram_addr_gen
   import output_sram_pkg::*;
#(
   parameter int unsigned LEN_W = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  remain,
   output logic              last,
   output logic              range_err
);

   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  remain_q;
   logic [31:0]       end_addr;

   // Wide sum so the check cannot wrap for any base/len combination.
   assign end_addr  = 32'(base) + 32'(len);
   assign range_err = (end_addr > MAX_WORDS);

   // Plain +1: row 2047 carries naturally into the bank field.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q   <= '0;
         remain_q <= '0;
      end else if (load) begin
         addr_q   <= base;
         remain_q <= len;
      end else if (step) begin
         addr_q   <= addr_q + ADDR_W'(1);
         remain_q <= remain_q - LEN_W'(1);
      end
   end

   assign addr   = addr_q;
   assign remain = remain_q;
   assign last   = (remain_q == LEN_W'(1));

endmodule

// File: rtl/output_sram_streamer.sv
// Output-SRAM streamer: executes one STORE or DRAIN command at a time against the
// pulse-request SRAM interface.
//   clock, reset             : clock, asynchronous active-low reset
//   cmd_valid/ready/dir/base/len : command handshake (dir 0=STORE, 1=DRAIN)
//   in_valid/ready/data      : STORE word stream into the SRAM
//   out_valid/ready/data     : DRAIN word stream out of the SRAM
//   done, err                : 1-cycle completion / error pulses (err also pulses done)
//   w_en, w_addr, w_d, w_done: write request pulse, address, data, acknowledge
//   r_en, r_addr, r_d, d_ready: read request pulse, address, data, data-valid
// All outputs are registered so that they are all 0 while reset is asserted.
module output_sram_streamer
   import output_sram_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned LEN_W   = 14
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              done,
   output logic              err,
   output logic              w_en,
   output logic              r_en,
   output logic [31:0]       w_addr,
   output logic [31:0]       r_addr,
   output logic [DATA_W-1:0] w_d,
   input  logic [DATA_W-1:0] r_d,
   input  logic              w_done,
   input  logic              d_ready
);

   localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

   state_t            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              w_en_q, w_en_d;
   logic              r_en_q, r_en_d;
   logic [31:0]       w_addr_q, w_addr_d;
   logic [31:0]       r_addr_q, r_addr_d;
   logic [DATA_W-1:0] w_d_q, w_d_d;

   logic              ag_load, ag_step;
   logic [ADDR_W-1:0] ag_addr;
   logic [LEN_W-1:0]  ag_remain;
   logic              ag_last, ag_range_err;
   logic              timed_out;

   output_sram_addr_gen #(
      .LEN_W (LEN_W)
   ) u_addr_gen (
      .clock     (clock),
      .reset     (reset),
      .load      (ag_load),
      .step      (ag_step),
      .base      (cmd_base),
      .len       (cmd_len),
      .addr      (ag_addr),
      .remain    (ag_remain),
      .last      (ag_last),
      .range_err (ag_range_err)
   );

   // Abort on the cycle that would take the timer to TIMEOUT, so err lands exactly
   // TIMEOUT cycles after the request pulse.
   assign timed_out = (timer_q == TimerW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      w_en_d      = 1'b0;
      r_en_d      = 1'b0;
      w_addr_d    = w_addr_q;
      r_addr_d    = r_addr_q;
      w_d_d       = w_d_q;
      ag_load     = 1'b0;
      ag_step     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready_q) begin
               if (ag_range_err) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else if (cmd_len == '0) begin
                  state_d = StFin;
               end else begin
                  ag_load = 1'b1;
                  state_d = (cmd_dir_t'(cmd_dir) == DirDrain) ? StRReq : StWReq;
               end
            end
         end
         StWReq: begin
            if (in_valid) begin
               w_en_d   = 1'b1;
               w_addr_d = {{(32 - ADDR_W){1'b0}}, ag_addr};
               w_d_d    = in_data;
               timer_d  = '0;
               state_d  = StWWait;
            end
         end
         StWWait: begin
            if (w_done) begin
               ag_step = 1'b1;
               state_d = ag_last ? StFin : StWReq;
            end else if (timed_out) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StRReq: begin
            r_en_d   = 1'b1;
            r_addr_d = {{(32 - ADDR_W){1'b0}}, ag_addr};
            timer_d  = '0;
            state_d  = StRWait;
         end
         StRWait: begin
            if (d_ready) begin
               out_data_d  = r_d;
               out_valid_d = 1'b1;
               ag_step     = 1'b1;
               state_d     = StRHold;
            end else if (timed_out) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StRHold: begin
            // remain was already decremented when the word was captured.
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = (ag_remain == '0) ? StFin : StRReq;
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      cmd_ready_d = (state_d == StIdle);
      in_ready_d  = (state_d == StWReq);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         cmd_ready_q <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         w_en_q      <= 1'b0;
         r_en_q      <= 1'b0;
         w_addr_q    <= '0;
         r_addr_q    <= '0;
         w_d_q       <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cmd_ready_q <= cmd_ready_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
         w_en_q      <= w_en_d;
         r_en_q      <= r_en_d;
         w_addr_q    <= w_addr_d;
         r_addr_q    <= r_addr_d;
         w_d_q       <= w_d_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign w_en      = w_en_q;
   assign r_en      = r_en_q;
   assign w_addr    = w_addr_q;
   assign r_addr    = r_addr_q;
   assign w_d       = w_d_q;

endmodule
